// File: rtl/raid5_pkg.sv
// raid5_pkg: shared types and constants for the RAID-5 SD stripe datapath
package raid5_pkg;
  localparam int DATA_W = 32;
  localparam int BLOCK_WORDS = 128;
  localparam int AW = $clog2(BLOCK_WORDS);
  typedef logic [1:0] sd_id_t;
  typedef enum logic [1:0] {IDLE, CHECK, STREAM, DONE} reader_state_t;
  typedef enum logic [1:0] {NORMAL, DEGRADED_DATA, DEGRADED_PARITY} rebuild_mode_t;
endpackage

// File: rtl/stripe_rebuild_xor.sv
// stripe_rebuild_xor: maps the two data drives to sram1/sram2, rebuilds a failed data drive, flags parity mismatch
module stripe_rebuild_xor
  import raid5_pkg::*;
(
  input  logic [DATA_W-1:0] sd1,
  input  logic [DATA_W-1:0] sd2,
  input  logic [DATA_W-1:0] sd3,
  input  sd_id_t            parity_sd,
  input  sd_id_t            failed_sd,
  input  rebuild_mode_t     mode,
  output logic [DATA_W-1:0] word1,
  output logic [DATA_W-1:0] word2,
  output logic              mismatch
);
  logic [DATA_W-1:0] all, lo, hi;
  sd_id_t lo_id, hi_id;
  logic rb;
  // XOR of all three words XOR one word equals the XOR of the other two
  always_comb begin
    all = sd1 ^ sd2 ^ sd3;
    lo_id = parity_sd == 2'd1 ? 2'd2 : 2'd1;
    hi_id = parity_sd == 2'd3 ? 2'd2 : 2'd3;
    lo = lo_id == 2'd1 ? sd1 : sd2;
    hi = hi_id == 2'd2 ? sd2 : sd3;
    rb = mode == DEGRADED_DATA;
    word1 = rb && failed_sd == lo_id ? all ^ lo : lo;
    word2 = rb && failed_sd == hi_id ? all ^ hi : hi;
    mismatch = mode == NORMAL && |all;
  end
endmodule

// File: rtl/sd_stripe_reader.sv
// sd_stripe_reader: reads one block from three SD cards into two SRAMs with parity check and single-drive rebuild
module sd_stripe_reader
  import raid5_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [1:0]        parity_sd,
  input  logic [5:0]        sd_error,
  input  logic              sd_valid,
  input  logic [DATA_W-1:0] sd1_data,
  input  logic [DATA_W-1:0] sd2_data,
  input  logic [DATA_W-1:0] sd3_data,
  output logic              sram1_write_enable,
  output logic              sram2_write_enable,
  output logic [AW-1:0]     sram_addr,
  output logic [DATA_W-1:0] sram1_data,
  output logic [DATA_W-1:0] sram2_data,
  output logic              busy,
  output logic              done,
  output logic              parity_mismatch,
  output logic              unrecoverable
);
  reader_state_t state;
  rebuild_mode_t mode;
  logic [2:0] failed;
  sd_id_t par, fid;
  logic [AW-1:0] addr;
  logic [2:0] err_now;
  logic [1:0] nfail;
  sd_id_t fid_now;
  logic new_fault, mis;
  logic [DATA_W-1:0] w1, w2;
  assign err_now = {|sd_error[5:4], |sd_error[3:2], |sd_error[1:0]};
  assign nfail = 2'(err_now[0]) + 2'(err_now[1]) + 2'(err_now[2]);
  assign fid_now = err_now[0] ? 2'd1 : err_now[1] ? 2'd2 : err_now[2] ? 2'd3 : 2'd0;
  assign new_fault = |(err_now & ~failed);
  stripe_rebuild_xor u_xor (
    .sd1(sd1_data),
    .sd2(sd2_data),
    .sd3(sd3_data),
    .parity_sd(par),
    .failed_sd(fid),
    .mode(mode),
    .word1(w1),
    .word2(w2),
    .mismatch(mis)
  );
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      mode <= NORMAL;
      failed <= '0;
      par <= '0;
      fid <= '0;
      addr <= '0;
      sram1_write_enable <= 1'b0;
      sram2_write_enable <= 1'b0;
      sram_addr <= '0;
      sram1_data <= '0;
      sram2_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      parity_mismatch <= 1'b0;
      unrecoverable <= 1'b0;
    end else begin
      sram1_write_enable <= 1'b0;
      sram2_write_enable <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= CHECK;
          busy <= 1'b1;
          parity_mismatch <= 1'b0;
          unrecoverable <= 1'b0;
          addr <= '0;
        end
        CHECK: begin
          failed <= err_now;
          par <= parity_sd;
          fid <= fid_now;
          if (nfail >= 2'd2 || parity_sd == 2'd0) begin
            unrecoverable <= 1'b1;
            done <= 1'b1;
            state <= DONE;
          end else begin
            mode <= nfail == 2'd0 ? NORMAL : fid_now == parity_sd ? DEGRADED_PARITY : DEGRADED_DATA;
            state <= STREAM;
          end
        end
        STREAM: if (new_fault) begin
          unrecoverable <= 1'b1;
          done <= 1'b1;
          state <= DONE;
        end else if (sd_valid) begin
          sram1_write_enable <= 1'b1;
          sram2_write_enable <= 1'b1;
          sram_addr <= addr;
          sram1_data <= w1;
          sram2_data <= w2;
          addr <= addr + 1'b1;
          if (mis) parity_mismatch <= 1'b1;
          if (addr == AW'(BLOCK_WORDS - 1)) begin
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
